// File: rtl/sync_filter_multi.sv
// sync_filter_multi: multi-channel input conditioner for asynchronous pins.
// Each channel passes through a flip-flop synchronizer, then a stability
// filter that only accepts a new level after it has been seen for FILTER_CNT
// consecutive cycles, and finally produces one-cycle rise/fall pulses.
module sync_filter_multi #(
   parameter int                NUM_CH      = 4,
   parameter int                SYNC_STAGES = 2,
   parameter int                FILTER_CNT  = 3,
   parameter logic [NUM_CH-1:0] RST_VAL     = '0
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [NUM_CH-1:0] async_in,
   output logic [NUM_CH-1:0] sync_out,
   output logic [NUM_CH-1:0] filt_out,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic              any_edge
);

   localparam int              CNT_W    = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);

   logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
   logic [CNT_W-1:0]  cnt_q  [NUM_CH];

   // Synchronizer shift chain; every stage idles at the reset value so that
   // leaving reset never looks like an input transition.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= RST_VAL;
         end
      end else begin
         sync_q[0] <= async_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Stability filter and edge pulses: a channel's counter runs while the
   // synchronized level differs from the filtered one and commits the new
   // level on the FILTER_CNT-th consecutive differing cycle. An unknown
   // comparison falls into the "equal" branch, so X never reaches filt_out.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         filt_out   <= RST_VAL;
         rise_pulse <= '0;
         fall_pulse <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_q[ch] <= '0;
         end
      end else begin
         rise_pulse <= '0;
         fall_pulse <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sync_out[ch] != filt_out[ch]) begin
               if (cnt_q[ch] == CNT_LAST) begin
                  filt_out[ch]   <= sync_out[ch];
                  cnt_q[ch]      <= '0;
                  rise_pulse[ch] <= sync_out[ch];
                  fall_pulse[ch] <= ~sync_out[ch];
               end else begin
                  cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
               end
            end else begin
               cnt_q[ch] <= '0;
            end
         end
      end
   end

   assign any_edge = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_filter_multi.sv
// tb_sync_filter_multi: scenario-driven bench for sync_filter_multi with a
// sliding-window reference model (a level is accepted once the last
// FILTER_CNT synchronized samples all disagree with the current filtered one).
module tb_sync_filter_multi;

   localparam int         NCH  = 4;
   localparam int         SYNC = 2;
   localparam int         FILT = 3;
   localparam logic [3:0] RST  = 4'b0101;

   logic       tb_clk;
   logic       n_rst;
   logic [3:0] async_in;
   logic [3:0] sync_out, filt_out, rise_pulse, fall_pulse;
   logic       any_edge;

   int tests_run;
   int tests_failed;

   logic [3:0] inq [$];
   logic [3:0] syq [$];
   logic [3:0] sync_m, filt_m, rise_m, fall_m;

   wire [16:0] obs_v = {sync_out, filt_out, rise_pulse, fall_pulse, any_edge};
   wire [16:0] exp_v = {sync_m, filt_m, rise_m, fall_m, |(rise_m | fall_m)};

   sync_filter_multi #(
      .NUM_CH      (NCH),
      .SYNC_STAGES (SYNC),
      .FILTER_CNT  (FILT),
      .RST_VAL     (RST)
   ) dut (
      .clk        (tb_clk),
      .n_rst      (n_rst),
      .async_in   (async_in),
      .sync_out   (sync_out),
      .filt_out   (filt_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .any_edge   (any_edge)
   );

   // Free-running bench clock.
   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   task automatic model_reset();
      inq.delete();
      syq.delete();
      sync_m = RST;
      filt_m = RST;
      rise_m = '0;
      fall_m = '0;
   endtask

   // One clock edge of the reference: window test on past synchronized
   // samples, then append the newly captured input.
   task automatic model_step(input logic [3:0] v);
      int         n;
      logic [3:0] s;
      logic [3:0] nxt;
      logic       differ_all;
      n      = inq.size();
      nxt    = filt_m;
      rise_m = '0;
      fall_m = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         differ_all = 1'b1;
         for (int k = 1; k <= FILT; k++) begin
            if (n - k < 0) s = RST;
            else           s = syq[n-k];
            if (s[ch] == filt_m[ch]) differ_all = 1'b0;
         end
         if (differ_all) begin
            nxt[ch] = ~filt_m[ch];
            if (nxt[ch]) rise_m[ch] = 1'b1;
            else         fall_m[ch] = 1'b1;
         end
      end
      filt_m = nxt;
      inq.push_back(v);
      if (n - (SYNC - 1) < 0) sync_m = RST;
      else                    sync_m = inq[n-(SYNC-1)];
      syq.push_back(sync_m);
   endtask

   task automatic tick();
      @(posedge tb_clk);
      model_step(async_in);
      @(negedge tb_clk);
   endtask

   task automatic test_reset();
      n_rst    = 1'b1;
      async_in = 4'($urandom);
      repeat (3) @(negedge tb_clk);
      #2 n_rst = 1'b0;
      #1;
      tests_run++;
      if (obs_v !== {RST, RST, 4'b0, 4'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_immediate got %b want %b", obs_v, {RST, RST, 9'b0});
      end
      repeat (2) @(posedge tb_clk);
      @(negedge tb_clk);
      tests_run++;
      if (obs_v !== {RST, RST, 4'b0, 4'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_held got %b want %b", obs_v, {RST, RST, 9'b0});
      end
      async_in = RST;
      n_rst    = 1'b1;
      model_reset();
      for (int t = 1; t <= 10; t++) begin
         tick();
         tests_run++;
         if (obs_v !== exp_v || (rise_pulse | fall_pulse) !== 4'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release cyc %0d got %b want %b", t, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_latency();
      async_in[1] = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         tick();
         tests_run++;
         if (obs_v !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL latency_model cyc %0d got %b want %b", t, obs_v, exp_v);
         end
         if (t == 2) begin
            tests_run++;
            if (sync_out[1] !== 1'b1) begin
               tests_failed++;
               $display("[TB] FAIL latency_sync got %b want 1", sync_out[1]);
            end
         end
         if (t == 4) begin
            tests_run++;
            if (filt_out[1] !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL latency_early got %b want 0", filt_out[1]);
            end
         end
         if (t == 5) begin
            tests_run++;
            if (filt_out[1] !== 1'b1 || rise_pulse !== 4'b0010) begin
               tests_failed++;
               $display("[TB] FAIL latency_filt got f=%b r=%b want f=1 r=0010", filt_out[1], rise_pulse);
            end
         end
         if (t == 6) begin
            tests_run++;
            if (rise_pulse !== 4'b0000) begin
               tests_failed++;
               $display("[TB] FAIL latency_pulse_clear got %b want 0000", rise_pulse);
            end
         end
      end
   endtask

   task automatic test_glitch();
      int nfall;
      nfall = 0;
      async_in[0] = 1'b0;
      for (int t = 1; t <= 10; t++) begin
         if (t == 3) async_in[0] = 1'b1;
         tick();
         if (fall_pulse != 4'b0) nfall++;
         tests_run++;
         if (obs_v !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL glitch_short_model cyc %0d got %b want %b", t, obs_v, exp_v);
         end
      end
      tests_run++;
      if (nfall != 0 || filt_out[0] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL glitch_short got falls=%0d f0=%b want falls=0 f0=1", nfall, filt_out[0]);
      end
      async_in[0] = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         if (t == 4) async_in[0] = 1'b1;
         tick();
         tests_run++;
         if (obs_v !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL glitch_long_model cyc %0d got %b want %b", t, obs_v, exp_v);
         end
         if (t == 5) begin
            tests_run++;
            if (fall_pulse !== 4'b0001 || filt_out[0] !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL glitch_long got fl=%b f0=%b want fl=0001 f0=0", fall_pulse, filt_out[0]);
            end
         end
         if (t == 6) begin
            tests_run++;
            if (fall_pulse !== 4'b0000) begin
               tests_failed++;
               $display("[TB] FAIL glitch_pulse_clear got %b want 0000", fall_pulse);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      async_in = 4'b0101;
      for (int t = 1; t <= 8; t++) tick();
      async_in = 4'b0011;
      for (int t = 1; t <= 8; t++) begin
         tick();
         tests_run++;
         if (obs_v !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL simul_model cyc %0d got %b want %b", t, obs_v, exp_v);
         end
         if (t == 5) begin
            tests_run++;
            if (rise_pulse !== 4'b0010 || fall_pulse !== 4'b0100 || any_edge !== 1'b1) begin
               tests_failed++;
               $display("[TB] FAIL simul_edges got r=%b fl=%b a=%b want r=0010 fl=0100 a=1",
                        rise_pulse, fall_pulse, any_edge);
            end
         end
         if (t == 4 || t == 6) begin
            tests_run++;
            if (any_edge !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL simul_any_quiet cyc %0d got %b want 0", t, any_edge);
            end
         end
      end
   endtask

   task automatic test_reset_midway();
      async_in = 4'b1011;
      for (int t = 1; t <= 4; t++) tick();
      n_rst = 1'b0;
      #1;
      tests_run++;
      if (obs_v !== {RST, RST, 4'b0, 4'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL midreset_values got %b want %b", obs_v, {RST, RST, 9'b0});
      end
      model_reset();
      @(negedge tb_clk);
      n_rst = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         tests_run++;
         if (obs_v !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL midreset_model cyc %0d got %b want %b", t, obs_v, exp_v);
         end
         if (t == 4 || t == 5) begin
            tests_run++;
            if (filt_out[3] !== (t == 5)) begin
               tests_failed++;
               $display("[TB] FAIL midreset_latency cyc %0d got %b want %b", t, filt_out[3], (t == 5));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int t = 1; t <= 400; t++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            if ($urandom_range(0, 2) == 0) async_in[ch] = ~async_in[ch];
         end
         tick();
         tests_run++;
         if (obs_v !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL random_model cyc %0d in=%b got %b want %b", t, async_in, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_metastable();
      bit settled;
      async_in[3] = 1'b0;
      repeat (8) @(negedge tb_clk);
      for (int i = 0; i < 5; i++) begin
         #4 async_in[3] = ~async_in[3];
         @(negedge tb_clk);
      end
      #4 async_in[3] = 1'b1;
      settled = 1'b0;
      for (int e = 1; e <= SYNC + 1 + FILT && !settled; e++) begin
         @(negedge tb_clk);
         tests_run++;
         if ($isunknown({filt_out, rise_pulse, fall_pulse, any_edge})) begin
            tests_failed++;
            $display("[TB] FAIL meta_unknown edge %0d got %b", e, obs_v);
         end
         if (filt_out[3] === 1'b1) settled = 1'b1;
      end
      tests_run++;
      if (!settled) begin
         tests_failed++;
         $display("[TB] FAIL meta_settle got f3=%b want 1 within %0d edges", filt_out[3], SYNC + 1 + FILT);
      end
      async_in[3] = 1'bx;
      for (int t = 1; t <= 100; t++) begin
         @(negedge tb_clk);
         tests_run++;
         if ($isunknown({filt_out, rise_pulse, fall_pulse, any_edge})) begin
            tests_failed++;
            $display("[TB] FAIL xin_unknown cyc %0d got %b", t, obs_v);
         end
      end
      async_in[3] = 1'b1;
      settled = 1'b0;
      for (int e = 1; e <= SYNC + 1 + FILT && !settled; e++) begin
         @(negedge tb_clk);
         if (filt_out[3] === 1'b1) settled = 1'b1;
      end
      tests_run++;
      if (!settled) begin
         tests_failed++;
         $display("[TB] FAIL xin_settle got f3=%b want 1 within %0d edges", filt_out[3], SYNC + 1 + FILT);
      end
   endtask

   // Scenario sequence, then the single summary line.
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      model_reset();
      test_reset();
      test_latency();
      test_glitch();
      test_simultaneous();
      test_reset_midway();
      test_random();
      test_metastable();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
